// File: rtl/cve2_data_bus_arbiter.sv
// Two-host to one-device data bus arbiter (req/gnt/rvalid).
// Hosts share one device port. A stalled request holds the port
// until it is granted. A small ID FIFO records the granting host so
// that in-order responses are routed back to the host that issued them.
//
// Handshake semantics: on every interface a request is accepted in the
// cycle where req and gnt are both high. The requester keeps req,
// address and controls stable until that cycle. Each accepted request
// produces exactly one rvalid cycle later, and responses return in order.
// rvalid is never back-pressured.
module cve2_data_bus_arbiter #(
  parameter int MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        h0_req_i,
  input  logic        h1_req_i,
  output logic        h0_gnt_o,
  output logic        h1_gnt_o,
  output logic        h0_rvalid_o,
  output logic        h1_rvalid_o,
  input  logic [31:0] h0_addr_i,
  input  logic [31:0] h1_addr_i,
  input  logic        h0_we_i,
  input  logic        h1_we_i,
  input  logic [3:0]  h0_be_i,
  input  logic [3:0]  h1_be_i,
  input  logic [31:0] h0_wdata_i,
  input  logic [31:0] h1_wdata_i,
  output logic [31:0] h_rdata_o,
  output logic        h_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic [2:0]  outstanding_o,
  output logic        busy_o,
  output logic        spurious_rsp_o
);

  localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
  localparam logic [1:0] PtrLast = 2'(MaxOutstanding - 1);

  // Arbitration state.
  logic       r_rr;       // host favoured on the next two-way contention
  logic       r_lock;     // a request was presented but not yet granted
  logic       r_lock_id;  // host owning the stalled request
  // Response routing state. The ID FIFO is sized for the largest legal depth.
  // Only entries below MaxOutstanding are addressed.
  logic [3:0] r_fifo;
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;

  logic w_sel;
  logic w_sel_req;
  logic w_full;
  logic w_hs;
  logic w_pop;
  logic w_head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PtrLast) ? 2'd0 : p + 2'd1;
  endfunction

  // Host selection: a stalled request keeps the port. Otherwise a lone
  // requester wins, and a tie goes to the round-robin favourite.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock) begin
      w_sel = r_lock_id;
    end else if (h0_req_i && !h1_req_i) begin
      w_sel = 1'b0;
    end else if (h1_req_i && !h0_req_i) begin
      w_sel = 1'b1;
    end else if (h0_req_i && h1_req_i) begin
      w_sel = r_rr;
    end
  end

  // Device-side request and payload mux. Fullness comes from the registered
  // count only, so a response never combinationally enables a request.
  always_comb begin
    w_full       = (r_count == MaxCnt);
    w_sel_req    = w_sel ? h1_req_i : h0_req_i;
    data_req_o   = w_sel_req & ~w_full;
    data_addr_o  = w_sel ? h1_addr_i  : h0_addr_i;
    data_we_o    = w_sel ? h1_we_i    : h0_we_i;
    data_be_o    = w_sel ? h1_be_i    : h0_be_i;
    data_wdata_o = w_sel ? h1_wdata_i : h0_wdata_i;
    w_hs         = data_req_o & data_gnt_i;
    h0_gnt_o     = w_hs & ~w_sel;
    h1_gnt_o     = w_hs & w_sel;
  end

  // Response routing: pass data through and steer rvalid by the FIFO head.
  always_comb begin
    w_pop          = data_rvalid_i & (r_count != 3'd0);
    w_head         = r_fifo[r_rptr];
    h0_rvalid_o    = w_pop & ~w_head;
    h1_rvalid_o    = w_pop & w_head;
    h_rdata_o      = data_rdata_i;
    h_err_o        = data_err_i;
    spurious_rsp_o = data_rvalid_i & (r_count == 3'd0);
    outstanding_o  = r_count;
    busy_o         = (r_count != 3'd0) | r_lock;
  end

  // Lock and round-robin update. The lock is taken only while the device
  // actually sees a stalled request. A dropped request releases it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr      <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      r_lock <= data_req_o & ~data_gnt_i;
      if (data_req_o && !data_gnt_i) begin
        r_lock_id <= w_sel;
      end
      if (w_hs) begin
        r_rr <= ~w_sel;
      end
    end
  end

  // ID FIFO: push the granted host on handshake, pop on each response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fifo  <= 4'd0;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_hs) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
